// File: rtl/emmc_init_seq_pkg.sv
// Shared eMMC definitions for the card-identification / bus-setup sequencer:
// response classes, failure causes, sequence steps and R1 card-status layout.
package emmc_init_seq_pkg;

  typedef enum logic [1:0] {
    RT_NONE = 2'd0,
    RT_R1   = 2'd1,
    RT_R2   = 2'd2,
    RT_R1B  = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_TIMEOUT  = 3'd1,
    ERR_OCR_BUSY = 3'd2,
    ERR_STATUS   = 3'd3,
    ERR_SWITCH   = 3'd4
  } init_err_e;

  typedef enum logic [2:0] {
    STEP_CMD0 = 3'd0,
    STEP_CMD1 = 3'd1,
    STEP_CMD2 = 3'd2,
    STEP_CMD3 = 3'd3,
    STEP_CMD9 = 3'd4,
    STEP_CMD7 = 3'd5,
    STEP_CMD6 = 3'd6
  } init_step_e;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_info_t;

  typedef struct packed {
    logic       address_out_of_range;
    logic       address_misalign;
    logic       block_len_error;
    logic       erase_seq_error;
    logic       erase_param;
    logic       wp_violation;
    logic       card_is_locked;
    logic       lock_unlock_failed;
    logic       com_crc_error;
    logic       illegal_command;
    logic       card_ecc_failed;
    logic       cc_error;
    logic       error;
    logic [1:0] rsvd_18_17;
    logic       cid_csd_overwrite;
    logic       wp_erase_skip;
    logic       rsvd_14;
    logic       erase_reset;
    logic [3:0] current_state;
    logic       ready_for_data;
    logic       switch_error;
    logic       exception_event;
    logic       app_cmd;
    logic [4:0] rsvd_4_0;
  } card_status_t;

  typedef struct packed {
    logic [5:0] rsvd_hi;
    logic [1:0] access;
    logic [7:0] index;
    logic [7:0] value;
    logic [4:0] rsvd_lo;
    logic [2:0] cmd_set;
  } cmd6arg_t;

  localparam logic [7:0] EXT_CSD_BUS_WIDTH_IDX = 8'd183;
  localparam logic [1:0] SWITCH_WRITE_BYTE     = 2'b11;

  // Bits 31..26 and 24..19 of card_status_t; card_is_locked (25) is informational.
  localparam logic [31:0] R1_ERR_MASK = 32'hFDF8_0000;

  function automatic logic r1_has_error(input logic [31:0] status);
    return |(status & R1_ERR_MASK);
  endfunction

  function automatic init_step_e next_step(input init_step_e s);
    case (s)
      STEP_CMD0: return STEP_CMD1;
      STEP_CMD1: return STEP_CMD2;
      STEP_CMD2: return STEP_CMD3;
      STEP_CMD3: return STEP_CMD9;
      STEP_CMD9: return STEP_CMD7;
      STEP_CMD7: return STEP_CMD6;
      default:   return STEP_CMD6;
    endcase
  endfunction

endpackage

// File: rtl/emmc_init_seq.sv
// eMMC power-up sequencer: CMD0, CMD1 (polled), CMD2, CMD3, CMD9, CMD7, CMD6,
// issuing each command over a valid/ready port and checking its response.
module emmc_init_seq
  import emmc_init_seq_pkg::*;
#(
  parameter logic [15:0]  RCA            = 16'h0001,
  parameter logic [31:0]  OCR_ARG        = 32'h40FF8080,
  parameter int unsigned  CMD1_RETRY_MAX = 1000,
  parameter int unsigned  CMD1_GAP       = 1024,
  parameter logic [7:0]   BUS_WIDTH_VAL  = 8'd2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  output logic         cmd_valid_o,
  input  logic         cmd_ready_i,
  output logic [37:0]  cmd_info_o,
  output logic [1:0]   resp_type_o,
  input  logic         resp_valid_i,
  input  logic         resp_timeout_i,
  input  logic [127:0] resp_i,
  input  logic         busy_i,
  output logic         done_o,
  output logic         err_o,
  output logic [2:0]   err_code_o,
  output logic [31:0]  ocr_o,
  output logic [127:0] cid_o,
  output logic [127:0] csd_o,
  output logic [15:0]  rca_o
);

  localparam int unsigned RW = $clog2(CMD1_RETRY_MAX + 1);
  localparam int unsigned GW = $clog2(CMD1_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_EVAL,
    S_GAP,
    S_WAIT_BUSY,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  init_step_e    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_arm_q, busy_arm_d;
  logic          cmd_valid_q, cmd_valid_d;
  cmd_info_t     cmd_info_q, cmd_info_d;
  resp_type_e    resp_type_q, resp_type_d;
  logic [127:0]  resp_q, resp_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  init_err_e     err_code_q, err_code_d;
  logic [31:0]   ocr_q, ocr_d;
  logic [127:0]  cid_q, cid_d;
  logic [127:0]  csd_q, csd_d;
  logic [15:0]   rca_q, rca_d;

  logic          issue, advance, fail;
  init_err_e     fail_code;
  card_status_t  status;

  function automatic cmd_info_t cmd_of(input init_step_e s);
    cmd_info_t c;
    cmd6arg_t  a6;
    a6        = '0;
    a6.access = SWITCH_WRITE_BYTE;
    a6.index  = EXT_CSD_BUS_WIDTH_IDX;
    a6.value  = BUS_WIDTH_VAL;
    c         = '0;
    case (s)
      STEP_CMD0: c = '{idx: 6'd0, arg: '0};
      STEP_CMD1: c = '{idx: 6'd1, arg: OCR_ARG};
      STEP_CMD2: c = '{idx: 6'd2, arg: '0};
      STEP_CMD3: c = '{idx: 6'd3, arg: {RCA, 16'h0000}};
      STEP_CMD9: c = '{idx: 6'd9, arg: {RCA, 16'h0000}};
      STEP_CMD7: c = '{idx: 6'd7, arg: {RCA, 16'h0000}};
      STEP_CMD6: c = '{idx: 6'd6, arg: a6};
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic resp_type_e rtype_of(input init_step_e s);
    case (s)
      STEP_CMD1, STEP_CMD3:  return RT_R1;
      STEP_CMD2, STEP_CMD9:  return RT_R2;
      STEP_CMD7, STEP_CMD6:  return RT_R1B;
      default:               return RT_NONE;
    endcase
  endfunction

  assign status    = card_status_t'(resp_q[31:0]);
  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    busy_arm_d  = busy_arm_q;
    cmd_valid_d = cmd_valid_q;
    cmd_info_d  = cmd_info_q;
    resp_type_d = resp_type_q;
    resp_d      = resp_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    ocr_d       = ocr_q;
    cid_d       = cid_q;
    csd_d       = csd_q;
    rca_d       = rca_q;
    issue       = 1'b0;
    advance     = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          retry_d    = '0;
          rca_d      = '0;
          step_d     = STEP_CMD0;
          issue      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (resp_timeout_i) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else if (resp_valid_i) begin
          resp_d  = resp_i;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        case (step_q)
          STEP_CMD1: begin
            ocr_d = resp_q[31:0];
            if (resp_q[31]) begin
              advance = 1'b1;
            end else if (retry_inc == RW'(CMD1_RETRY_MAX)) begin
              fail      = 1'b1;
              fail_code = ERR_OCR_BUSY;
            end else begin
              retry_d = retry_inc;
              gap_d   = '0;
              state_d = S_GAP;
            end
          end
          STEP_CMD2: begin
            cid_d   = resp_q;
            advance = 1'b1;
          end
          STEP_CMD9: begin
            csd_d   = resp_q;
            advance = 1'b1;
          end
          STEP_CMD3, STEP_CMD7, STEP_CMD6: begin
            if (r1_has_error(resp_q[31:0])) begin
              fail      = 1'b1;
              fail_code = ERR_STATUS;
            end else if (step_q == STEP_CMD6 && status.switch_error) begin
              fail      = 1'b1;
              fail_code = ERR_SWITCH;
            end else if (step_q == STEP_CMD3) begin
              rca_d   = RCA;
              advance = 1'b1;
            end else begin
              busy_arm_d = 1'b0;
              state_d    = S_WAIT_BUSY;
            end
          end
          default: advance = 1'b1;
        endcase
      end
      S_GAP: begin
        if (gap_q == GW'(CMD1_GAP - 1)) issue = 1'b1;
        else                            gap_d = gap_q + GW'(1);
      end
      S_WAIT_BUSY: begin
        // First cycle is skipped so the card has time to pull DAT0 low.
        if (!busy_arm_q)  busy_arm_d = 1'b1;
        else if (!busy_i) advance    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (step_q == STEP_CMD6) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        step_d = next_step(step_q);
        issue  = 1'b1;
      end
    end

    if (fail) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end

    if (issue) begin
      state_d     = S_ISSUE;
      cmd_valid_d = 1'b1;
      cmd_info_d  = cmd_of(step_d);
      resp_type_d = rtype_of(step_d);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      step_q      <= STEP_CMD0;
      retry_q     <= '0;
      gap_q       <= '0;
      busy_arm_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_info_q  <= '0;
      resp_type_q <= RT_NONE;
      resp_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ocr_q       <= '0;
      cid_q       <= '0;
      csd_q       <= '0;
      rca_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      busy_arm_q  <= busy_arm_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_info_q  <= cmd_info_d;
      resp_type_q <= resp_type_d;
      resp_q      <= resp_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ocr_q       <= ocr_d;
      cid_q       <= cid_d;
      csd_q       <= csd_d;
      rca_q       <= rca_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_info_o  = cmd_info_q;
  assign resp_type_o = resp_type_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign ocr_o       = ocr_q;
  assign cid_o       = cid_q;
  assign csd_o       = csd_q;
  assign rca_o       = rca_q;

endmodule

// File: tb/tb_emmc_init_seq.sv
// Bench for emmc_init_seq: plays the card/transceiver role and compares the
// command stream and final outputs against a rule-based expectation.
module tb_emmc_init_seq;

  localparam int unsigned RETRY_MAX = 4;
  localparam int unsigned GAP       = 32;
  localparam int          LIMIT     = 20000;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b0;
  logic         start_i = 1'b0;
  logic         cmd_valid_o;
  logic         cmd_ready_i = 1'b0;
  logic [37:0]  cmd_info_o;
  logic [1:0]   resp_type_o;
  logic         resp_valid_i = 1'b0;
  logic         resp_timeout_i = 1'b0;
  logic [127:0] resp_i = '0;
  logic         busy_i = 1'b0;
  logic         done_o, err_o;
  logic [2:0]   err_code_o;
  logic [31:0]  ocr_o;
  logic [127:0] cid_o, csd_o;
  logic [15:0]  rca_o;

  emmc_init_seq #(
    .RCA           (16'h0001),
    .OCR_ARG       (32'h40FF8080),
    .CMD1_RETRY_MAX(RETRY_MAX),
    .CMD1_GAP      (GAP),
    .BUS_WIDTH_VAL (8'd2)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_info_o    (cmd_info_o),
    .resp_type_o   (resp_type_o),
    .resp_valid_i  (resp_valid_i),
    .resp_timeout_i(resp_timeout_i),
    .resp_i        (resp_i),
    .busy_i        (busy_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .ocr_o         (ocr_o),
    .cid_o         (cid_o),
    .csd_o         (csd_o),
    .rca_o         (rca_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nready;
    int stall_idx;
    int stall_n;
    int busy7;
    int busy6;
    int fault_idx;
    int fault_kind;   // 0 none, 1 timeout, 2 valid+timeout, 3 status error, 4 switch error
    int err_bit;
    int rst_idx;
    int start_idx;
  } scen_t;

  int           total = 0;
  int           bad = 0;
  longint       cyc = 0;
  logic [31:0]  exp_ocr;
  logic [127:0] exp_cid, exp_csd;
  logic [31:0]  err_mask;
  int           err_pos [12] = '{31, 30, 29, 28, 27, 26, 24, 23, 22, 21, 20, 19};
  int           cmd_order [5] = '{2, 3, 9, 7, 6};
  int           obs_q [$];
  int           exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Command table as written in the eMMC flow: {arg, response class}.
  function automatic logic [33:0] ref_cmd(input int idx);
    case (idx)
      0:       return {32'h0000_0000, 2'd0};
      1:       return {32'h40FF_8080, 2'd1};
      2:       return {32'h0000_0000, 2'd2};
      3:       return {32'h0001_0000, 2'd1};
      9:       return {32'h0001_0000, 2'd2};
      7:       return {32'h0001_0000, 2'd3};
      6:       return {32'h03B7_0200, 2'd3};
      default: return {32'hDEAD_BEEF, 2'd0};
    endcase
  endfunction

  function automatic int code_of(input int kind);
    if (kind == 1 || kind == 2) return 1;
    return kind;
  endfunction

  function automatic scen_t base();
    scen_t s;
    s.nready = 0; s.stall_idx = -1; s.stall_n = 0; s.busy7 = 2; s.busy6 = 2;
    s.fault_idx = -1; s.fault_kind = 0; s.err_bit = -1; s.rst_idx = -1; s.start_idx = -1;
    return s;
  endfunction

  task automatic check_all_zero(input string name);
    chk({name, " zero_ctrl"}, {cmd_valid_o, resp_type_o, done_o, err_o, err_code_o}, '0);
    chk({name, " zero_info"}, cmd_info_o, '0);
    chk({name, " zero_ocr"}, ocr_o, '0);
    chk({name, " zero_cid"}, cid_o, '0);
    chk({name, " zero_csd"}, csd_o, '0);
    chk({name, " zero_rca"}, rca_o, '0);
  endtask

  task automatic run(input scen_t s, input string name);
    int           exp_code, k, n1, budget, idx, fault, bn, pos;
    bit           stop, rca_set, reset_hit, have_hs, r1b_ok;
    longint       last_hs;
    logic [37:0]  info;
    logic [33:0]  ec;
    logic [127:0] p;
    logic [31:0]  st;

    // Expected command stream and outcome, straight from the flow rules.
    exp_q.delete();
    obs_q.delete();
    exp_code = 0; stop = 0; rca_set = 0;
    exp_q.push_back(0);
    if (s.fault_idx == 0) begin stop = 1; exp_code = code_of(s.fault_kind); end
    if (!stop) begin
      k = (s.nready >= int'(RETRY_MAX)) ? int'(RETRY_MAX) : s.nready + 1;
      repeat (k) exp_q.push_back(1);
      if (s.nready >= int'(RETRY_MAX)) begin stop = 1; exp_code = 2; end
    end
    for (int i = 0; i < 5 && !stop; i++) begin
      exp_q.push_back(cmd_order[i]);
      if (cmd_order[i] == s.rst_idx) stop = 1;
      else if (cmd_order[i] == s.fault_idx) begin stop = 1; exp_code = code_of(s.fault_kind); end
      else if (cmd_order[i] == 3) rca_set = 1;
    end

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({name, " start_valid"}, cmd_valid_o, 1'b1);
    chk({name, " start_clears"}, {done_o, err_o, err_code_o, rca_o}, '0);

    budget = 0; n1 = 0; reset_hit = 0; have_hs = 0; last_hs = 0;
    while (!done_o && !err_o && !reset_hit && budget < LIMIT) begin
      if (!cmd_valid_o) begin
        tick();
        budget++;
      end else begin
        info = cmd_info_o;
        idx  = int'(info[37:32]);
        obs_q.push_back(idx);
        ec = ref_cmd(idx);
        chk($sformatf("%s cmd%0d_arg", name, idx), info[31:0], ec[33:2]);
        chk($sformatf("%s cmd%0d_rtype", name, idx), resp_type_o, ec[1:0]);
        if (idx == 1 && have_hs)
          chk($sformatf("%s cmd1_gap", name), ((cyc - last_hs) >= longint'(GAP)), 1'b1);
        if (idx == s.stall_idx) begin
          for (int i = 0; i < s.stall_n; i++) begin
            tick();
            chk($sformatf("%s stall_valid%0d", name, i), cmd_valid_o, 1'b1);
            chk($sformatf("%s stall_info%0d", name, i), cmd_info_o, info);
          end
        end
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        chk($sformatf("%s cmd%0d_valid_drop", name, idx), cmd_valid_o, 1'b0);
        if (idx == 1) begin last_hs = cyc; have_hs = 1; end

        if (idx == s.rst_idx) begin
          rstn_i = 1'b0;
          #2;
          check_all_zero({name, " midrst"});
          #2;
          rstn_i = 1'b1;
          exp_ocr = '0; exp_cid = '0; exp_csd = '0;
          reset_hit = 1;
        end else begin
          if (idx == s.start_idx) start_i = 1'b1;
          tick();
          start_i = 1'b0;

          fault = (idx == s.fault_idx) ? s.fault_kind : 0;
          p = '0;
          case (idx)
            1: begin
              n1++;
              p[31:0] = {(n1 > s.nready), 31'($urandom())};
            end
            2, 9: p = {$urandom(), $urandom(), $urandom(), $urandom()};
            3, 7, 6: begin
              st = $urandom() & ~err_mask & ~32'h0000_0080;
              pos = (s.err_bit >= 0) ? s.err_bit : err_pos[$urandom_range(0, 11)];
              if (fault == 3) st[pos] = 1'b1;
              if (fault == 4) st[7] = 1'b1;
              p[31:0] = st;
            end
            default: p = '0;
          endcase
          r1b_ok = (idx == 7 || idx == 6) && fault == 0;
          bn = (idx == 7) ? s.busy7 : s.busy6;
          resp_i         = p;
          resp_valid_i   = (fault != 1);
          resp_timeout_i = (fault == 1 || fault == 2);
          if (r1b_ok && bn > 0) busy_i = 1'b1;
          tick();
          resp_valid_i   = 1'b0;
          resp_timeout_i = 1'b0;
          resp_i         = {$urandom(), $urandom(), $urandom(), $urandom()};
          if (idx == 1) exp_ocr = p[31:0];
          if (fault == 0 && idx == 2) exp_cid = p;
          if (fault == 0 && idx == 9) exp_csd = p;
          if (r1b_ok && bn > 0) begin
            for (int i = 0; i < bn; i++) begin
              chk($sformatf("%s busy%0d_no_cmd%0d", name, idx, i), cmd_valid_o, 1'b0);
              tick();
            end
            busy_i = 1'b0;
          end
        end
      end
    end

    chk({name, " finished_in_budget"}, (budget < LIMIT), 1'b1);
    chk({name, " cmd_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s cmd_seq%0d", name, i), obs_q[i], exp_q[i]);
    if (reset_hit) begin
      repeat (3) tick();
      chk({name, " idle_after_rst"}, {cmd_valid_o, done_o, err_o}, '0);
    end else begin
      chk({name, " done"}, done_o, !stop);
      chk({name, " err"}, err_o, stop);
      chk({name, " err_code"}, err_code_o, exp_code);
      chk({name, " rca"}, rca_o, rca_set ? 16'h0001 : 16'h0000);
      chk({name, " ocr"}, ocr_o, exp_ocr);
      chk({name, " cid"}, cid_o, exp_cid);
      chk({name, " csd"}, csd_o, exp_csd);
    end
    repeat (4) tick();
  endtask

  initial begin
    scen_t s;
    int    sel;
    int    fidx [6] = '{0, 2, 3, 9, 7, 6};
    int    ridx [3] = '{3, 7, 6};

    err_mask = '0;
    foreach (err_pos[i]) err_mask[err_pos[i]] = 1'b1;
    exp_ocr = '0; exp_cid = '0; exp_csd = '0;

    repeat (3) tick();
    check_all_zero("reset");
    rstn_i = 1'b1;
    tick();

    s = base(); s.nready = 2; s.stall_idx = 2; s.stall_n = 5; s.busy7 = 20; s.busy6 = 3;
    s.start_idx = 3;
    run(s, "nominal");

    s = base(); s.rst_idx = 9;
    run(s, "rst_cmd9");

    s = base(); s.nready = 1; s.fault_idx = 3; s.fault_kind = 1;
    run(s, "timeout_cmd3");

    s = base(); s.fault_idx = 2; s.fault_kind = 2;
    run(s, "both_cmd2");

    s = base(); s.nready = RETRY_MAX;
    run(s, "ocr_never_ready");

    s = base(); s.fault_idx = 6; s.fault_kind = 4;
    run(s, "switch_err");

    s = base(); s.fault_idx = 7; s.fault_kind = 3; s.err_bit = 22;
    run(s, "illegal_cmd7");

    for (int r = 0; r < 8; r++) begin
      s = base();
      s.nready    = $urandom_range(0, RETRY_MAX);
      s.stall_idx = fidx[$urandom_range(0, 5)];
      s.stall_n   = $urandom_range(0, 4);
      s.busy7     = $urandom_range(1, 6);
      s.busy6     = $urandom_range(1, 6);
      sel = $urandom_range(0, 4);
      if (sel == 1 || sel == 2) begin
        s.fault_kind = sel; s.fault_idx = fidx[$urandom_range(0, 5)];
      end else if (sel == 3) begin
        s.fault_kind = 3; s.fault_idx = ridx[$urandom_range(0, 2)];
      end else if (sel == 4) begin
        s.fault_kind = 4; s.fault_idx = 6;
      end
      run(s, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
